// File: rtl/corrige_hamming_secded.sv
// corrige_hamming_secded
// ----------------------
// Two-stage pipelined SECDED (extended Hamming) decoder with a valid/ready
// streaming handshake and saturating error statistics.
//
// Codeword layout: entrada[0] is the overall even parity bit, entrada[p]
// (p >= 1) holds Hamming position p. Power-of-two positions are parity bits,
// every other position carries data in ascending order (data[0] at
// position 3). Legal parameter sets satisfy DATA_W + R <= 2**R - 1.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   entrada[CODE_W]            received codeword
//   entrada_valida / _pronta   input handshake
//   saida[DATA_W]              corrected data
//   saida_valida / _pronta     output handshake
//   erro_corrigido             single-bit error corrected in this word
//   erro_duplo                 uncorrectable error detected in this word
//   limpa_contadores           synchronous clear of both counters
//   contador_corrigidos[CNT_W] delivered words with erro_corrigido set
//   contador_duplos[CNT_W]     delivered words with erro_duplo set

module corrige_hamming_secded #(
  parameter int DATA_W = 11,
  parameter int R      = 4,
  parameter int CODE_W = DATA_W + R + 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] entrada,
  input  logic              entrada_valida,
  output logic              entrada_pronta,
  output logic [DATA_W-1:0] saida,
  output logic              saida_valida,
  input  logic              saida_pronta,
  output logic              erro_corrigido,
  output logic              erro_duplo,
  input  logic              limpa_contadores,
  output logic [CNT_W-1:0]  contador_corrigidos,
  output logic [CNT_W-1:0]  contador_duplos
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Hamming position of the i-th data bit: the i-th position (counting from
  // 1) that is not a power of two.
  function automatic int data_pos(input int i);
    int cnt;
    data_pos = 0;
    cnt = 0;
    for (int p = 1; p < CODE_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == i) data_pos = p;
        cnt++;
      end
    end
  endfunction

  // ---------------------------------------------------------------------
  // Handshake ready chain
  // ---------------------------------------------------------------------
  logic v1, v2;
  logic pronta1, pronta2;

  // A stage can take a new word when it is empty or its content is leaving.
  always_comb begin
    pronta2 = !v2 || saida_pronta;
    pronta1 = !v1 || pronta2;
  end

  assign entrada_pronta = pronta1;

  // ---------------------------------------------------------------------
  // Stage 1: syndrome and overall parity of the incoming word
  // ---------------------------------------------------------------------
  logic [R-1:0]      syn_c;
  logic              op_c;
  logic [CODE_W-1:0] cw1;
  logic [R-1:0]      syn1;
  logic              op1;

  // Syndrome bit k covers every position whose index has bit k set; the
  // overall parity covers the whole word including bit 0.
  always_comb begin
    syn_c = '0;
    op_c  = ^entrada;
    for (int p = 1; p < CODE_W; p++) begin
      for (int k = 0; k < R; k++) begin
        if (((p >> k) & 1) == 1) syn_c[k] = syn_c[k] ^ entrada[p];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      cw1  <= '0;
      syn1 <= '0;
      op1  <= 1'b0;
    end else if (pronta1) begin
      v1 <= entrada_valida;
      if (entrada_valida) begin
        cw1  <= entrada;
        syn1 <= syn_c;
        op1  <= op_c;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2 combinational: classify, correct, extract
  // ---------------------------------------------------------------------
  logic              syn_in_range;
  logic              corr_c;
  logic              dbl_c;
  logic [CODE_W-1:0] cw_fix;
  logic [DATA_W-1:0] data_c;
  logic              unused_cw_bits;

  // A shortened code leaves syndromes >= CODE_W pointing at nonexistent
  // positions; with op=1 those are reported as uncorrectable. A zero
  // syndrome with op=1 means only the overall parity bit was hit, which
  // needs no data change.
  always_comb begin
    syn_in_range = (int'(syn1) < CODE_W);
    corr_c       = op1 && syn_in_range;
    dbl_c        = (op1 && !syn_in_range) || (!op1 && (syn1 != '0));
  end

  // Flip the addressed position only for a correctable single error.
  always_comb begin
    cw_fix = cw1;
    for (int p = 1; p < CODE_W; p++) begin
      if (corr_c && (int'(syn1) == p)) cw_fix[p] = ~cw1[p];
    end
  end

  for (genvar i = 0; i < DATA_W; i++) begin : g_extract
    localparam int POS = data_pos(i);
    assign data_c[i] = cw_fix[POS];
  end

  // Parity positions are not part of the delivered data.
  assign unused_cw_bits = ^cw_fix;

  // ---------------------------------------------------------------------
  // Stage 2 registers: corrected data and flags
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] data2;
  logic              corr2;
  logic              dbl2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      data2 <= '0;
      corr2 <= 1'b0;
      dbl2  <= 1'b0;
    end else if (pronta2) begin
      v2 <= v1;
      if (v1) begin
        data2 <= data_c;
        corr2 <= corr_c;
        dbl2  <= dbl_c;
      end
    end
  end

  assign saida          = data2;
  assign saida_valida   = v2;
  assign erro_corrigido = corr2;
  assign erro_duplo     = dbl2;

  // ---------------------------------------------------------------------
  // Error statistics
  // ---------------------------------------------------------------------
  logic handshake;

  assign handshake = v2 && saida_pronta;

  // Counters only move on a delivered word; clear beats increment, and
  // both stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contador_corrigidos <= '0;
      contador_duplos     <= '0;
    end else if (limpa_contadores) begin
      contador_corrigidos <= '0;
      contador_duplos     <= '0;
    end else if (handshake) begin
      if (corr2 && (contador_corrigidos != CNT_MAX))
        contador_corrigidos <= contador_corrigidos + CNT_ONE;
      if (dbl2 && (contador_duplos != CNT_MAX))
        contador_duplos <= contador_duplos + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_corrige_hamming_secded.sv
// tb_corrige_hamming_secded
// -------------------------
// Self-checking bench for corrige_hamming_secded. Three instances:
//   dut_a  default (16,11) code, 16-bit counters
//   dut_b  DATA_W=8 shortened code (CODE_W=13)
//   dut_c  default code with 2-bit counters
// Expected values are hand-computed constants.

module tb_corrige_hamming_secded;

  logic clk;
  logic rst_n;

  // dut_a signals
  logic [15:0] a_entrada;
  logic        a_entrada_valida, a_entrada_pronta;
  logic [10:0] a_saida;
  logic        a_saida_valida, a_saida_pronta;
  logic        a_erro_corrigido, a_erro_duplo, a_limpa;
  logic [15:0] a_cnt_corr, a_cnt_dbl;

  // dut_b signals
  logic [12:0] b_entrada;
  logic        b_entrada_valida, b_entrada_pronta;
  logic [7:0]  b_saida;
  logic        b_saida_valida, b_saida_pronta;
  logic        b_erro_corrigido, b_erro_duplo, b_limpa;
  logic [15:0] b_cnt_corr, b_cnt_dbl;

  // dut_c signals
  logic [15:0] c_entrada;
  logic        c_entrada_valida, c_entrada_pronta;
  logic [10:0] c_saida;
  logic        c_saida_valida, c_saida_pronta;
  logic        c_erro_corrigido, c_erro_duplo, c_limpa;
  logic [1:0]  c_cnt_corr, c_cnt_dbl;

  int checks = 0;
  int errors = 0;
  int exp_corr_a = 0;
  int exp_dbl_a  = 0;

  corrige_hamming_secded dut_a (
    .clk(clk), .rst_n(rst_n),
    .entrada(a_entrada), .entrada_valida(a_entrada_valida), .entrada_pronta(a_entrada_pronta),
    .saida(a_saida), .saida_valida(a_saida_valida), .saida_pronta(a_saida_pronta),
    .erro_corrigido(a_erro_corrigido), .erro_duplo(a_erro_duplo),
    .limpa_contadores(a_limpa),
    .contador_corrigidos(a_cnt_corr), .contador_duplos(a_cnt_dbl)
  );

  corrige_hamming_secded #(.DATA_W(8), .R(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .entrada(b_entrada), .entrada_valida(b_entrada_valida), .entrada_pronta(b_entrada_pronta),
    .saida(b_saida), .saida_valida(b_saida_valida), .saida_pronta(b_saida_pronta),
    .erro_corrigido(b_erro_corrigido), .erro_duplo(b_erro_duplo),
    .limpa_contadores(b_limpa),
    .contador_corrigidos(b_cnt_corr), .contador_duplos(b_cnt_dbl)
  );

  corrige_hamming_secded #(.CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .entrada(c_entrada), .entrada_valida(c_entrada_valida), .entrada_pronta(c_entrada_pronta),
    .saida(c_saida), .saida_valida(c_saida_valida), .saida_pronta(c_saida_pronta),
    .erro_corrigido(c_erro_corrigido), .erro_duplo(c_erro_duplo),
    .limpa_contadores(c_limpa),
    .contador_corrigidos(c_cnt_corr), .contador_duplos(c_cnt_dbl)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] cw;
    logic [10:0] data;
    logic        corr;
    logic        dbl;
  } vec_t;

  vec_t vecs[12];

  logic [15:0] bp_cw[8];
  logic [10:0] bp_data[8];

  // One comparison; a mismatch prints a FAIL line and bumps the error count.
  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Push one word through dut_a with the consumer always ready; check
  // latency, data, flags, counters and that the pipeline drains.
  task automatic applyStimulus(input vec_t v);
    int wait_cycles;
    @(negedge clk);
    a_entrada        = v.cw;
    a_entrada_valida = 1'b1;
    @(negedge clk);
    a_entrada_valida = 1'b0;
    a_entrada        = '0;
    wait_cycles = 0;
    while (!a_saida_valida && wait_cycles < 8) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (!a_saida_valida) begin
      checkOutput("a_timeout", 32'd0, 32'd1);
    end else begin
      checkOutput("a_latency", wait_cycles, 1);
      checkOutput("a_data", a_saida, v.data);
      checkOutput("a_corr", a_erro_corrigido, v.corr);
      checkOutput("a_dbl", a_erro_duplo, v.dbl);
      exp_corr_a += int'(v.corr);
      exp_dbl_a  += int'(v.dbl);
      @(negedge clk);
      checkOutput("a_cnt_corr", a_cnt_corr, exp_corr_a);
      checkOutput("a_cnt_dbl", a_cnt_dbl, exp_dbl_a);
      checkOutput("a_drained", a_saida_valida, 0);
    end
  endtask

  // Same flow for the shortened-code instance.
  task automatic applyStimulusB(input logic [12:0] cw, input logic [7:0] d,
                                input logic corr, input logic dbl);
    int wait_cycles;
    @(negedge clk);
    b_entrada        = cw;
    b_entrada_valida = 1'b1;
    @(negedge clk);
    b_entrada_valida = 1'b0;
    wait_cycles = 0;
    while (!b_saida_valida && wait_cycles < 8) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (!b_saida_valida) begin
      checkOutput("b_timeout", 32'd0, 32'd1);
    end else begin
      checkOutput("b_data", b_saida, d);
      checkOutput("b_corr", b_erro_corrigido, corr);
      checkOutput("b_dbl", b_erro_duplo, dbl);
      @(negedge clk);
    end
  endtask

  // Send one single-error word to dut_c, optionally clearing the counters
  // on the very cycle of its output handshake.
  task automatic sendC(input logic clear_on_hs);
    int wait_cycles;
    @(negedge clk);
    c_entrada        = 16'hFFDF;
    c_entrada_valida = 1'b1;
    @(negedge clk);
    c_entrada_valida = 1'b0;
    wait_cycles = 0;
    while (!c_saida_valida && wait_cycles < 8) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (!c_saida_valida) begin
      checkOutput("c_timeout", 32'd0, 32'd1);
    end else begin
      checkOutput("c_corr_flag", c_erro_corrigido, 1);
      c_limpa = clear_on_hs;
      @(negedge clk);
      c_limpa = 1'b0;
    end
  endtask

  initial begin
    int in_idx, out_idx, cyc;
    logic stalled_prev, saw_drop;
    logic [12:0] held;
    logic pat[4];

    // Single-error, double-error and clean vectors for the (16,11) code.
    vecs[0]  = '{16'hFFFF, 11'h7FF, 1'b0, 1'b0};
    vecs[1]  = '{16'hFFDF, 11'h7FF, 1'b1, 1'b0};
    vecs[2]  = '{16'hFFFE, 11'h7FF, 1'b1, 1'b0};
    vecs[3]  = '{16'hFFB7, 11'h7FA, 1'b0, 1'b1};
    vecs[4]  = '{16'h0000, 11'h000, 1'b0, 1'b0};
    vecs[5]  = '{16'h000F, 11'h001, 1'b0, 1'b0};
    vecs[6]  = '{16'h800F, 11'h001, 1'b1, 1'b0};
    vecs[7]  = '{16'h0007, 11'h001, 1'b1, 1'b0};
    vecs[8]  = '{16'h0009, 11'h001, 1'b0, 1'b1};
    vecs[9]  = '{16'h8117, 11'h400, 1'b0, 1'b0};
    vecs[10] = '{16'h8017, 11'h400, 1'b1, 1'b0};
    vecs[11] = '{16'h8317, 11'h400, 1'b1, 1'b0};

    bp_cw = '{16'h0000, 16'hFFFF, 16'h000F, 16'h8117, 16'hFFF0, 16'h7EE8, 16'h8118, 16'h7EE7};
    bp_data = '{11'h000, 11'h7FF, 11'h001, 11'h400, 11'h7FE, 11'h3FF, 11'h401, 11'h3FE};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0;
    a_entrada = '0; a_entrada_valida = 1'b0; a_saida_pronta = 1'b1; a_limpa = 1'b0;
    b_entrada = '0; b_entrada_valida = 1'b0; b_saida_pronta = 1'b1; b_limpa = 1'b0;
    c_entrada = '0; c_entrada_valida = 1'b0; c_saida_pronta = 1'b1; c_limpa = 1'b0;

    #12 rst_n = 1'b1;
    @(negedge clk);

    // Reset state.
    checkOutput("rst_valid", a_saida_valida, 0);
    checkOutput("rst_saida", a_saida, 0);
    checkOutput("rst_flags", {a_erro_corrigido, a_erro_duplo}, 0);
    checkOutput("rst_cnt_corr", a_cnt_corr, 0);
    checkOutput("rst_cnt_dbl", a_cnt_dbl, 0);
    checkOutput("rst_pronta", a_entrada_pronta, 1);

    // Directed vector table on the default code.
    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

    // Shortened code: syndrome 13 is outside a 13-bit word.
    applyStimulusB(13'h0112, 8'h00, 1'b0, 1'b1);
    applyStimulusB(13'h0000, 8'h00, 1'b0, 1'b0);
    applyStimulusB(13'h1000, 8'h00, 1'b1, 1'b0);
    applyStimulusB(13'h000F, 8'h01, 1'b0, 1'b0);
    checkOutput("b_cnt_dbl", b_cnt_dbl, 1);
    checkOutput("b_cnt_corr", b_cnt_corr, 1);

    // Backpressure: eight clean words, consumer ready pattern 1,0,0,1.
    in_idx = 0; out_idx = 0; cyc = 0;
    stalled_prev = 1'b0; saw_drop = 1'b0; held = '0;
    while (out_idx < 8 && cyc < 200) begin
      @(negedge clk);
      a_saida_pronta   = pat[cyc % 4];
      a_entrada_valida = (in_idx < 8);
      a_entrada        = (in_idx < 8) ? bp_cw[in_idx] : 16'h0000;
      #1;
      if (stalled_prev) begin
        checkOutput("stall_valid", a_saida_valida, 1);
        checkOutput("stall_hold", {a_saida, a_erro_corrigido, a_erro_duplo}, held);
      end
      if (a_entrada_valida && !a_entrada_pronta) saw_drop = 1'b1;
      if (a_saida_valida && a_saida_pronta) begin
        checkOutput("bp_data", a_saida, bp_data[out_idx]);
        checkOutput("bp_flags", {a_erro_corrigido, a_erro_duplo}, 0);
        out_idx++;
      end
      stalled_prev = a_saida_valida && !a_saida_pronta;
      held = {a_saida, a_erro_corrigido, a_erro_duplo};
      if (a_entrada_valida && a_entrada_pronta) in_idx++;
      cyc++;
    end
    a_entrada_valida = 1'b0;
    a_saida_pronta   = 1'b1;
    checkOutput("bp_out_count", out_idx, 8);
    checkOutput("bp_in_count", in_idx, 8);
    checkOutput("bp_ready_drop", saw_drop, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_no_extra", a_saida_valida, 0);
    end
    checkOutput("bp_cnt_corr", a_cnt_corr, exp_corr_a);
    checkOutput("bp_cnt_dbl", a_cnt_dbl, exp_dbl_a);

    // Saturation with 2-bit counters: five corrected words, back to back.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      c_entrada        = 16'hFFDF;
      c_entrada_valida = 1'b1;
      #1;
      checkOutput("c_throughput", c_entrada_pronta, 1);
    end
    @(negedge clk);
    c_entrada_valida = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("c_saturate", c_cnt_corr, 3);
    checkOutput("c_cnt_dbl", c_cnt_dbl, 0);

    // Clear on the same cycle as a corrected handshake, from saturation
    // and again from a non-saturated value.
    sendC(1'b1);
    checkOutput("c_clear_sat", c_cnt_corr, 0);
    sendC(1'b0);
    checkOutput("c_inc_after_clear", c_cnt_corr, 1);
    sendC(1'b1);
    checkOutput("c_clear_wins", c_cnt_corr, 0);

    // Asynchronous reset with a word in flight.
    @(negedge clk);
    a_entrada        = 16'hFFDF;
    a_entrada_valida = 1'b1;
    @(negedge clk);
    a_entrada_valida = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("mid_inflight", a_saida_valida, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_valid", a_saida_valida, 0);
    checkOutput("mid_cnt_corr", a_cnt_corr, 0);
    checkOutput("mid_cnt_dbl", a_cnt_dbl, 0);
    checkOutput("mid_pronta", a_entrada_pronta, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("mid_discarded", a_saida_valida, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
